if_stage: RTL
=============

# if_stage

Instruction fetch stage: owns the architectural fetch PC and the 64-bit instruction order counter. Issues one instruction-memory read at a time and pushes each returned word as a `fetch_pkt_t` into the instruction queue that feeds `id_stage`. It is the single producer of that queue. It honours ROB flush/redirect by discarding in-flight wrong-path responses, and optionally attaches a static branch prediction to each packet.

## Interface
Parameters:
- `RESET_PC`, default `32'h1eceb000`: fetch PC loaded on reset.

Ports:
- `clk` in 1: clock; sole clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `imem_addr` out 32: read address; held stable while a request is outstanding.
- `imem_rmask` out 4: `4'hF` while a request is outstanding, `4'h0` otherwise.
- `imem_rdata` in 32: read data; valid in the `imem_resp` cycle.
- `imem_resp` in 1: one-cycle response strobe.
- `fifo_full` in 1: instruction queue cannot accept a push.
- `fifo_push` out 1: write strobe into the instruction queue.
- `fifo_in` out `fetch_pkt_t`: `{inst, pc, order}` written with `fifo_push`.
- `predict_taken` out 1: prediction queued alongside `fifo_in`.
- `pc_target` out 32: predicted next PC queued alongside `fifo_in`.
- `flush` in 1: ROB redirect strobe.
- `flush_pc` in 32: redirect PC.
- `flush_order` in 64: order value for the first correct-path instruction.

## Operation
- Registers:
  - `pc`
  - `order`
  - `req_addr`
  - state ∈ {IDLE, REQ, DROP}
- IDLE:
  - If `!fifo_full && !flush`: `req_addr<=pc` and go to REQ.
  - If `flush`: `pc<=flush_pc`, `order<=flush_order`, stay in IDLE.
- REQ:
  - `imem_addr=req_addr`, `imem_rmask=4'hF`.
  - On `imem_resp && !flush`:
    - `fifo_push=1`, `fifo_in={imem_rdata, req_addr, order}`.
    - `order<=order+1`, `pc<=pc_target`, go to IDLE.
  - On `flush` without `imem_resp`: `pc<=flush_pc`, `order<=flush_order`, go to DROP.
  - On `flush` with `imem_resp`: response discarded, no push, load `flush_pc`/`flush_order`, go to IDLE.
- DROP:
  - The request stays asserted at the old `req_addr` until `imem_resp`.
  - The response is discarded; never push. Then go to IDLE.
  - A further `flush` in DROP reloads `pc`/`order` and keeps the state, or goes to IDLE if it coincides with `imem_resp`.
- No overflow: a request is issued only when `!fifo_full`. This block is the only producer, so space cannot disappear before the response.
- `order` wraps modulo 2^64 with no special handling. `pc+4` wraps modulo 2^32.
- `fifo_push` is never asserted outside the REQ response cycle.

## Timing
- Reset (async assert) values:
  - state=IDLE, `pc=RESET_PC`, `order=0`, `req_addr=RESET_PC`.
  - `imem_rmask=0`, `fifo_push=0`, `fifo_in='0`, `predict_taken=0`, `pc_target=RESET_PC+4`.
- Reset deasserting mid-request: the memory must tolerate an abandoned request. The block restarts at `RESET_PC`.
- Latency:
  - IDLE→REQ: 1 cycle.
  - The push is combinational in the `imem_resp` cycle.
  - One mandatory IDLE bubble follows each push, so peak throughput is 1 instruction per 2 cycles with zero-wait memory.
- `flush` has priority over `imem_resp` and over `fifo_full` in every state.
- `predict_taken` and `pc_target` are combinational from `imem_rdata` and `req_addr`. They are meaningful only when `fifo_push=1`.

## Configuration
- `IF_STATIC_PREDICT_EN` defined:
  - `op_b_jal` predicts taken with `pc_target=pc+j_imm`.
  - `op_b_br` with negative `b_imm` (backward) predicts taken with `pc_target=pc+b_imm`.
  - Everything else (including `op_b_jalr`) is not taken with `pc_target=pc+4`.
  - The next fetch PC is `pc_target`.
- Undefined: `predict_taken=0`, `pc_target=pc+4` always; pure sequential fetch.

## Structure
- `rv32i_types` already provides `fetch_pkt_t`, `op_b_br` and `op_b_jal`.
- `rv32i_types` gains `if_state_t` (IDLE/REQ/DROP) and the `RESET_PC` default constant.
- One combinational sub-module, `static_predictor`, takes inst and pc and produces predict_taken and pc_target. It is instantiated only under `IF_STATIC_PREDICT_EN`.

## Test plan
- **Reset and first fetch:** Reset, then a 1-cycle-latency memory returning `32'h00000013`. Expect `imem_addr=1eceb000` and a push of `{00000013, 1eceb000, 0}`. The next request is at `1eceb004` with order 1.
- **Queue full:** Hold `fifo_full=1` for 5 cycles in IDLE. Expect `imem_rmask=0` throughout. Release: a request is issued on the next cycle.
- **Flush while outstanding:** `flush` with `flush_pc=1eceb100`, `flush_order=7` while in REQ at `1eceb008`. The stale response is dropped with no push. The next request is at `1eceb100` and the pushed order is 7.
- **Flush coinciding with response:** `flush` in the same cycle as `imem_resp`. Expect no push and a direct return to IDLE with the new PC.
- **Prediction enabled (`IF_STATIC_PREDICT_EN`):** At `pc=1eceb010`, `beq` with `b_imm=-16` gives `predict_taken=1`, `pc_target=1eceb000`, and the next fetch is at `1eceb000`. `jalr` gives `predict_taken=0`.
- **Prediction disabled:** Same stream without the macro. Every packet has `predict_taken=0` and `pc_target=pc+4`.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the front end.
// Provides the fetch packet pushed into the instruction queue, the base opcodes
// that fetch and static prediction decode, the fetch FSM state type, and the
// default reset PC.
package rv32i_types;

  // Base opcodes (inst[6:0]).
  localparam logic [6:0] op_b_br   = 7'b1100011;
  localparam logic [6:0] op_b_jalr = 7'b1100111;
  localparam logic [6:0] op_b_jal  = 7'b1101111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } if_state_t;

endpackage

// File: rtl/static_predictor.sv
// Static branch predictor (purely combinational).
// Ports:
//   inst          in  32  fetched instruction word
//   pc            in  32  address of inst
//   predict_taken out 1   1 for jal and for backward conditional branches
//   pc_target     out 32  predicted next PC (pc+4 when not taken)
// jalr is never predicted: its target depends on a register value.
module static_predictor
  import rv32i_types::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        predict_taken,
  output logic [31:0] pc_target
);

  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign opcode = inst[6:0];
  assign j_imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign b_imm  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    predict_taken = 1'b0;
    pc_target     = pc + 32'd4;
    if (opcode == op_b_jal) begin
      predict_taken = 1'b1;
      pc_target     = pc + j_imm;
    end else if (opcode == op_b_br && b_imm[31]) begin
      // Backward branches are most likely loop back-edges.
      predict_taken = 1'b1;
      pc_target     = pc + b_imm;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Owns the fetch PC and the 64-bit instruction order counter, issues one
// instruction-memory read at a time and pushes each returned word into the
// instruction queue. A ROB flush redirects fetch; a response still in flight
// at flush time is discarded (DROP state).
// Optional feature macro: IF_STATIC_PREDICT_EN attaches a static prediction
// (static_predictor) and follows it; otherwise fetch is purely sequential.
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_addr/imem_rmask      read request (rmask 4'hF while outstanding)
//   imem_rdata/imem_resp      read data and one-cycle response strobe
//   fifo_full                 queue cannot accept a push
//   fifo_push/fifo_in         queue write strobe and packet {inst, pc, order}
//   predict_taken/pc_target   prediction queued with fifo_in
//   flush/flush_pc/flush_order ROB redirect
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        fifo_full,
  output logic        fifo_push,
  output fetch_pkt_t  fifo_in,
  output logic        predict_taken,
  output logic [31:0] pc_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [63:0] flush_order
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] order_q, order_d;
  logic [31:0] req_addr_q, req_addr_d;

`ifdef IF_STATIC_PREDICT_EN
  static_predictor u_static_predictor (
    .inst          (imem_rdata),
    .pc            (req_addr_q),
    .predict_taken (predict_taken),
    .pc_target     (pc_target)
  );
`else
  assign predict_taken = 1'b0;
  assign pc_target     = req_addr_q + 32'd4;
`endif

  // The address is held from req_addr so it stays stable through REQ and DROP.
  assign imem_addr = req_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    order_d    = order_q;
    req_addr_d = req_addr_q;
    imem_rmask = 4'h0;
    fifo_push  = 1'b0;
    fifo_in    = '0;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          pc_d    = flush_pc;
          order_d = flush_order;
        end else if (!fifo_full) begin
          // Only producer of the queue: space seen here survives until the push.
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        imem_rmask = 4'hF;
        if (flush) begin
          pc_d    = flush_pc;
          order_d = flush_order;
          state_d = imem_resp ? IDLE : DROP;
        end else if (imem_resp) begin
          fifo_push = 1'b1;
          fifo_in   = '{inst: imem_rdata, pc: req_addr_q, order: order_q};
          order_d   = order_q + 64'd1;
          pc_d      = pc_target;
          state_d   = IDLE;
        end
      end
      DROP: begin
        // Wrong-path request must still complete before a new one is issued.
        imem_rmask = 4'hF;
        if (flush) begin
          pc_d    = flush_pc;
          order_d = flush_order;
        end
        if (imem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      order_q    <= 64'd0;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      order_q    <= order_d;
      req_addr_q <= req_addr_d;
    end
  end

endmodule
